// File: rtl/mbist_march.sv
// March C- memory BIST controller with a data-background parameter.
// Passes the system port straight to the SRAM whenever no test is running.
module mbist_march #(
  parameter int                SIZE         = 6,
  parameter int                LENGTH       = 8,
  parameter logic [LENGTH-1:0] BACKGROUND   = {LENGTH{1'b0}},
  parameter bit                STOP_ON_FAIL = 1'b0,
  parameter int                FCNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              csin,
  input  logic              rwbarin,
  input  logic [SIZE-1:0]   address,
  input  logic [LENGTH-1:0] datain,
  output logic              ram_cs,
  output logic              ram_rwbar,
  output logic [SIZE-1:0]   ram_addr,
  output logic [LENGTH-1:0] ram_din,
  input  logic [LENGTH-1:0] ram_dout,
  output logic [LENGTH-1:0] dataout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [SIZE-1:0]   fail_addr,
  output logic [2:0]        fail_elem,
  output logic [FCNT_W-1:0] fail_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [SIZE-1:0]   ADDR_MAX = {SIZE{1'b1}};
  localparam logic [SIZE-1:0]   ADDR_ONE = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic [SIZE-1:0]     addr_q, addr_d;
  logic                phase_q, phase_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [SIZE-1:0]     fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [LENGTH-1:0]   cmp_exp_q, cmp_exp_d;
  logic [SIZE-1:0]     cmp_addr_q, cmp_addr_d;
  logic [2:0]          cmp_elem_q, cmp_elem_d;

  logic                two_op, down, op_rd, op_one, addr_last, last_op, mismatch;
  logic [LENGTH-1:0]   op_data;
  logic                ctl_rwbar;

  // Current op decoded from (element, phase); phase 1 is the write of a r/w pair.
  always_comb begin
    two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    op_rd     = (elem_q != 3'd0) && !phase_q;
    op_one    = phase_q ? ((elem_q == 3'd1) || (elem_q == 3'd3))
                        : ((elem_q == 3'd2) || (elem_q == 3'd4));
    op_data   = op_one ? ~BACKGROUND : BACKGROUND;
    addr_last = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    last_op   = (elem_q == 3'd5) && (addr_q == ADDR_MAX);
    mismatch  = cmp_vld_q && (ram_dout != cmp_exp_q);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fcnt_d      = fcnt_q;
    cmp_vld_d   = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    ctl_rwbar   = 1'b1;

    if (mismatch) begin
      fail_d = 1'b1;
      if (fcnt_q != {FCNT_W{1'b1}}) fcnt_d = fcnt_q + FCNT_ONE;
      if (!fail_q) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          fcnt_d      = '0;
          elem_d      = '0;
          addr_d      = '0;
          phase_d     = 1'b0;
        end
      end
      RUN: begin
        // On an early stop the op slot degrades to a read with no compare.
        if (STOP_ON_FAIL && mismatch) begin
          state_d = DRAIN;
        end else begin
          ctl_rwbar = op_rd;
          if (op_rd) begin
            cmp_vld_d  = 1'b1;
            cmp_exp_d  = op_data;
            cmp_addr_d = addr_q;
            cmp_elem_d = elem_q;
          end
          if (last_op) begin
            state_d = DRAIN;
          end else if (two_op && !phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (addr_last) begin
              elem_d = elem_q + 3'd1;
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
            end else begin
              addr_d = down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
            end
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fcnt_q      <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fcnt_q      <= fcnt_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign ram_cs     = busy ? 1'b1      : csin;
  assign ram_rwbar  = busy ? ctl_rwbar : rwbarin;
  assign ram_addr   = busy ? addr_q    : address;
  assign ram_din    = busy ? op_data   : datain;
  assign dataout    = ram_dout;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_elem  = fail_elem_q;
  assign fail_count = fcnt_q;

endmodule

// File: tb/tb_mbist_march.sv
// Bench: three controller instances (plain, stop-on-fail, background A5) on
// behavioural SRAMs with stuck-bit faults, checked against a March C- op model.
module tb_mbist_march;
  localparam int SIZE = 6;
  localparam int LEN  = 8;
  localparam int N    = 64;
  localparam int NI   = 3;
  localparam int NOPS = 10 * N;

  typedef struct {
    int         addr;
    bit         rd;
    logic [7:0] dat;
    int         elem;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start   [NI];
  logic            csin    [NI];
  logic            rwbarin [NI];
  logic [SIZE-1:0] address [NI];
  logic [LEN-1:0]  datain  [NI];
  logic            ram_cs  [NI];
  logic            ram_rwbar [NI];
  logic [SIZE-1:0] ram_addr [NI];
  logic [LEN-1:0]  ram_din [NI];
  logic [LEN-1:0]  rdata   [NI];
  logic [LEN-1:0]  dataout [NI];
  logic            busy    [NI];
  logic            done    [NI];
  logic            fail    [NI];
  logic [SIZE-1:0] fail_addr [NI];
  logic [2:0]      fail_elem [NI];
  logic [7:0]      fail_count [NI];

  logic [LEN-1:0]  mem   [NI][N];
  logic [LEN-1:0]  smask [NI][N];
  logic [LEN-1:0]  sval  [NI][N];

  int   n_chk = 0;
  int   n_bad = 0;
  op_t  ops[$];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      mbist_march #(
        .SIZE(SIZE), .LENGTH(LEN),
        .BACKGROUND(g == 2 ? 8'hA5 : 8'h00),
        .STOP_ON_FAIL(g == 1), .FCNT_W(8)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start[g]),
        .csin(csin[g]), .rwbarin(rwbarin[g]), .address(address[g]), .datain(datain[g]),
        .ram_cs(ram_cs[g]), .ram_rwbar(ram_rwbar[g]), .ram_addr(ram_addr[g]),
        .ram_din(ram_din[g]), .ram_dout(rdata[g]), .dataout(dataout[g]),
        .busy(busy[g]), .done(done[g]), .fail(fail[g]),
        .fail_addr(fail_addr[g]), .fail_elem(fail_elem[g]), .fail_count(fail_count[g])
      );
    end
  endgenerate

  // Synchronous SRAM, 1-cycle read latency, stuck bits applied on read.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (ram_cs[g]) begin
        if (!ram_rwbar[g]) mem[g][ram_addr[g]] <= ram_din[g];
        else rdata[g] <= (mem[g][ram_addr[g]] & ~smask[g][ram_addr[g]]) |
                         (sval[g][ram_addr[g]] & smask[g][ram_addr[g]]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_faults();
    for (int g = 0; g < NI; g++)
      for (int a = 0; a < N; a++) begin
        smask[g][a] = '0;
        sval[g][a]  = '0;
      end
  endtask

  function automatic op_t mk(input int a, input bit rd, input logic [7:0] d, input int e);
    op_t o;
    o.addr = a; o.rd = rd; o.dat = d; o.elem = e;
    return o;
  endfunction

  // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0)
  task automatic build_ops(input logic [7:0] bg);
    logic [7:0] z, o;
    z = bg; o = ~bg;
    ops.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        int a;
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        case (e)
          0: ops.push_back(mk(a, 0, z, e));
          1: begin ops.push_back(mk(a, 1, z, e)); ops.push_back(mk(a, 0, o, e)); end
          2: begin ops.push_back(mk(a, 1, o, e)); ops.push_back(mk(a, 0, z, e)); end
          3: begin ops.push_back(mk(a, 1, z, e)); ops.push_back(mk(a, 0, o, e)); end
          4: begin ops.push_back(mk(a, 1, o, e)); ops.push_back(mk(a, 0, z, e)); end
          default: ops.push_back(mk(a, 1, z, e));
        endcase
      end
  endtask

  task automatic ref_march(input int g, input bit stop, output int cnt,
                           output int f_addr, output int f_elem, output int f_idx);
    logic [7:0] m [N];
    logic [7:0] obs;
    cnt = 0; f_addr = 0; f_elem = 0; f_idx = -1;
    for (int i = 0; i < ops.size(); i++) begin
      if (!ops[i].rd) m[ops[i].addr] = ops[i].dat;
      else begin
        obs = (m[ops[i].addr] & ~smask[g][ops[i].addr]) |
              (sval[g][ops[i].addr] & smask[g][ops[i].addr]);
        if (obs !== ops[i].dat) begin
          if (f_idx < 0) begin
            f_idx = i; f_addr = ops[i].addr; f_elem = ops[i].elem;
          end
          cnt++;
          if (stop) break;
        end
      end
    end
    if (cnt > 255) cnt = 255;
  endtask

  task automatic run_march(input int g, input logic [7:0] bg, input bit stop, input int restart_at);
    int cnt, f_addr, f_elem, f_idx, c, nops, exp_len;
    bit early;
    build_ops(bg);
    ref_march(g, stop, cnt, f_addr, f_elem, f_idx);
    early   = stop && (f_idx >= 0);
    nops    = early ? f_idx + 1 : NOPS;
    exp_len = early ? f_idx + 3 : NOPS + 1;
    repeat (2) @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    c = 0;
    while (busy[g] && c < 2000) begin
      if (c < nops)
        chk($sformatf("op%0d_%0d", g, c),
            {16'h0, ram_cs[g], ram_rwbar[g], ram_addr[g], ram_rwbar[g] ? 8'h00 : ram_din[g]},
            {16'h0, 1'b1, ops[c].rd, 6'(ops[c].addr), ops[c].rd ? 8'h00 : ops[c].dat});
      else if (c > nops || !early)
        chk($sformatf("nowr%0d_%0d", g, c), {31'h0, ram_cs[g] & ~ram_rwbar[g]}, 0);
      start[g] = (c == restart_at);
      @(negedge clk);
      c++;
    end
    start[g] = 1'b0;
    chk($sformatf("len%0d", g), c, exp_len);
    chk($sformatf("done%0d", g), {31'h0, done[g]}, 1);
    chk($sformatf("fail%0d", g), {31'h0, fail[g]}, {31'h0, f_idx >= 0});
    chk($sformatf("fcnt%0d", g), {24'h0, fail_count[g]}, cnt);
    chk($sformatf("faddr%0d", g), {26'h0, fail_addr[g]}, f_addr);
    chk($sformatf("felem%0d", g), {29'h0, fail_elem[g]}, f_elem);
    @(negedge clk);
    chk($sformatf("done_sticky%0d", g), {30'h0, done[g], busy[g]}, 2'b10);
  endtask

  task automatic idle_traffic(input int g, input int n);
    logic [7:0] sb [N];
    bit         sv [N];
    int         a;
    logic [7:0] d;
    for (int i = 0; i < N; i++) sv[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      a = $urandom_range(N - 1);
      if ($urandom_range(1) == 1 || !sv[a]) begin
        d = 8'($urandom);
        csin[g] = 1'b1; rwbarin[g] = 1'b0; address[g] = 6'(a); datain[g] = d;
        sb[a] = d; sv[a] = 1'b1;
        #1 chk("pass_wr", {16'h0, ram_cs[g], ram_rwbar[g], ram_addr[g], ram_din[g]},
               {16'h0, 1'b1, 1'b0, 6'(a), d});
        @(negedge clk);
      end else begin
        csin[g] = 1'b1; rwbarin[g] = 1'b1; address[g] = 6'(a);
        @(negedge clk);
        csin[g] = 1'b0;
        chk("rd_data", {24'h0, dataout[g]}, {24'h0, sb[a]});
      end
    end
    csin[g] = 1'b0;
  endtask

  initial begin
    int g, a, fc_before;
    logic [7:0] d;
    rst = 1'b1;
    clr_faults();
    for (int i = 0; i < NI; i++) begin
      start[i] = 0; csin[i] = 0; rwbarin[i] = 1; address[i] = '0; datain[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_flags", {28'h0, busy[i], done[i], fail[i], ram_cs[i]}, 0);
      chk("rst_fregs", {15'h0, fail_addr[i], fail_elem[i], fail_count[i]}, 0);
    end

    // Idle pass-through: write 3C to address 9, read it back.
    csin[0] = 1; rwbarin[0] = 0; address[0] = 6'd9; datain[0] = 8'h3C;
    @(negedge clk);
    rwbarin[0] = 1;
    @(negedge clk);
    csin[0] = 0;
    chk("idle_rd9", {24'h0, dataout[0]}, 32'h3C);
    idle_traffic(0, 24);

    // Fault-free, with a stray start mid-run.
    run_march(0, 8'h00, 0, 50);

    // Address 5 bit0 stuck-at-1, with and without stop-on-fail.
    smask[0][5] = 8'h01; sval[0][5] = 8'h01;
    smask[1][5] = 8'h01; sval[1][5] = 8'h01;
    run_march(0, 8'h00, 0, -1);
    run_march(1, 8'h00, 1, -1);

    // Background A5, address 63 stuck at A5.
    smask[2][63] = 8'hFF; sval[2][63] = 8'hA5;
    run_march(2, 8'hA5, 0, -1);

    // Every address stuck at 0F: fail counter saturates.
    clr_faults();
    for (int i = 0; i < N; i++) begin smask[0][i] = 8'hFF; sval[0][i] = 8'h0F; end
    run_march(0, 8'h00, 0, -1);

    // Random single-address faults on random instances.
    for (int k = 0; k < 5; k++) begin
      clr_faults();
      g = $urandom_range(NI - 1);
      a = $urandom_range(N - 1);
      smask[g][a] = 8'($urandom_range(255, 1));
      sval[g][a]  = 8'($urandom);
      run_march(g, g == 2 ? 8'hA5 : 8'h00, g == 1, -1);
    end

    // Normal-mode reads never touch the fail counter.
    clr_faults();
    fc_before = fail_count[2];
    idle_traffic(2, 16);
    chk("idle_nocmp", {24'h0, fail_count[2]}, fc_before);

    // Reset in the middle of a run.
    smask[0][7] = 8'h80; sval[0][7] = 8'h80;
    @(negedge clk);
    start[0] = 1;
    @(negedge clk);
    start[0] = 0;
    for (int c = 0; c < 100 && busy[0]; c++) @(negedge clk);
    chk("pre_rst_busy", {31'h0, busy[0]}, 1);
    d = 8'($urandom);
    rst = 1; csin[0] = 1; rwbarin[0] = 0; address[0] = 6'd17; datain[0] = d;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_flags", {29'h0, busy[0], done[0], fail[0]}, 0);
    chk("mid_rst_fcnt", {24'h0, fail_count[0]}, 0);
    chk("mid_rst_mux", {16'h0, ram_cs[0], ram_rwbar[0], ram_addr[0], ram_din[0]},
        {16'h0, 1'b1, 1'b0, 6'd17, d});
    csin[0] = 0;
    clr_faults();
    run_march(0, 8'h00, 0, -1);

    // start together with rst is dropped.
    @(negedge clk);
    rst = 1; start[0] = 1;
    @(negedge clk);
    rst = 0; start[0] = 0;
    chk("rst_start_a", {31'h0, busy[0]}, 0);
    @(negedge clk);
    chk("rst_start_b", {31'h0, busy[0]}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
